// File: rtl/cdc_rx_ctrl.sv
// cdc_rx_ctrl: read-side controller for the slow-to-fast byte CDC.
// Drives the CDC read-side reset, waits for a quiet line before accepting
// traffic, and delimits the raw byte stream into frames by inter-byte gap.
// Bytes are delayed by one slot in a hold register, so that the end-of-frame
// marker can be attached to the last byte once the gap (or an error) is seen.
module cdc_rx_ctrl #(
    parameter int RST_CYCLES = 8,
    parameter int IDLE_GAP   = 6,
    parameter int MAX_FRAME  = 1522,
    parameter int CNT_W      = 16
) (
    input  logic             clkIn,
    input  logic             rstNIn,
    output logic             cdcRstOut,
    input  logic [7:0]       cdcDataIn,
    input  logic             cdcValidIn,
    input  logic             cdcErrIn,
    input  logic             enIn,
    output logic [7:0]       dataOut,
    output logic             validOut,
    output logic             sofOut,
    output logic             eofOut,
    output logic             frameErrOut,
    output logic [CNT_W-1:0] errCntOut,
    output logic [CNT_W-1:0] frameCntOut
);

    localparam int BC_W = $clog2(MAX_FRAME + 1);
    localparam int RC_W = $clog2(RST_CYCLES);
    localparam int GC_W = $clog2(IDLE_GAP + 1);

    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [GC_W-1:0] GAP_FULL = GC_W'(IDLE_GAP);
    localparam logic [BC_W-1:0] BC_MAX   = BC_W'(MAX_FRAME);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_IDLE,
        S_IDLE,
        S_FRAME,
        S_DROP
    } state_t;

    state_t          state;
    logic [RC_W-1:0] rst_cnt;
    logic [GC_W-1:0] gap_cnt;
    logic [BC_W-1:0] byte_cnt;
    logic [7:0]      hold_byte;
    logic            hold_first;
    logic            gap_done;

    // The line counts as quiet once the gap counter has already saturated
    // and no byte arrives this cycle.
    assign gap_done = !cdcValidIn && (gap_cnt == GAP_FULL);

    // Sequencer, hold register, gap/byte counters and all registered outputs.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            // NOTE: the hold register is reset as well, so dataOut never
            // leaks a stale byte after reset.
            state       <= S_RESET;
            rst_cnt     <= '0;
            gap_cnt     <= '0;
            byte_cnt    <= '0;
            hold_byte   <= '0;
            hold_first  <= 1'b0;
            cdcRstOut   <= 1'b1;
            dataOut     <= '0;
            validOut    <= 1'b0;
            sofOut      <= 1'b0;
            eofOut      <= 1'b0;
            frameErrOut <= 1'b0;
            errCntOut   <= '0;
            frameCntOut <= '0;
        end else begin
            // NOTE: pulse outputs get a default here; non-blocking semantics
            // mean a later assignment in the case below simply overrides it.
            validOut    <= 1'b0;
            sofOut      <= 1'b0;
            eofOut      <= 1'b0;
            frameErrOut <= 1'b0;

            if (cdcValidIn) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_FULL) begin
                gap_cnt <= gap_cnt + GC_W'(1);
            end

            case (state)
                S_RESET: begin
                    gap_cnt <= '0;
                    if (rst_cnt == RC_LAST) begin
                        cdcRstOut <= 1'b0;
                        state     <= S_WAIT_IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end

                S_WAIT_IDLE: begin
                    if (gap_done) begin
                        state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (cdcErrIn) begin
                        state     <= S_RESET;
                        rst_cnt   <= '0;
                        cdcRstOut <= 1'b1;
                        if (!(&errCntOut)) errCntOut <= errCntOut + CNT_W'(1);
                    end else if (cdcValidIn) begin
                        if (enIn) begin
                            hold_byte  <= cdcDataIn;
                            hold_first <= 1'b1;
                            byte_cnt   <= BC_W'(1);
                            state      <= S_FRAME;
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end

                S_FRAME: begin
                    if (cdcErrIn) begin
                        // Truncate: flush the held byte as a bad end of frame.
                        dataOut     <= hold_byte;
                        validOut    <= 1'b1;
                        sofOut      <= hold_first;
                        eofOut      <= 1'b1;
                        frameErrOut <= 1'b1;
                        state       <= S_RESET;
                        rst_cnt     <= '0;
                        cdcRstOut   <= 1'b1;
                        if (!(&errCntOut)) errCntOut <= errCntOut + CNT_W'(1);
                    end else if (cdcValidIn) begin
                        dataOut  <= hold_byte;
                        validOut <= 1'b1;
                        sofOut   <= hold_first;
                        if (byte_cnt == BC_MAX) begin
                            // Oversize: close the frame as bad, drop the rest.
                            eofOut      <= 1'b1;
                            frameErrOut <= 1'b1;
                            state       <= S_DROP;
                        end else begin
                            hold_byte  <= cdcDataIn;
                            hold_first <= 1'b0;
                            byte_cnt   <= byte_cnt + BC_W'(1);
                        end
                    end else if (gap_done) begin
                        dataOut  <= hold_byte;
                        validOut <= 1'b1;
                        sofOut   <= hold_first;
                        eofOut   <= 1'b1;
                        state    <= S_IDLE;
                        if (!(&frameCntOut)) frameCntOut <= frameCntOut + CNT_W'(1);
                    end
                end

                S_DROP: begin
                    if (cdcErrIn) begin
                        state     <= S_RESET;
                        rst_cnt   <= '0;
                        cdcRstOut <= 1'b1;
                        if (!(&errCntOut)) errCntOut <= errCntOut + CNT_W'(1);
                    end else if (gap_done) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_RESET;
                    rst_cnt   <= '0;
                    cdcRstOut <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_rx_ctrl.sv
// Directed bench for cdc_rx_ctrl. MAX_FRAME is shrunk to 4 so oversize is
// reachable, and CNT_W to 2 so the frame counter saturation is exercised.
module tb_cdc_rx_ctrl;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cdc_rst;
    logic [7:0]       cdc_data;
    logic             cdc_valid;
    logic             cdc_err;
    logic             en;
    logic [7:0]       data;
    logic             valid;
    logic             sof;
    logic             eof;
    logic             frame_err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] frame_cnt;

    int compared   = 0;
    int mismatched = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [7:0]  d;
        logic        s;
        logic        e;
        logic        fe;
        logic [31:0] t;
    } ev_t;

    ev_t evq[$];

    cdc_rx_ctrl #(
        .RST_CYCLES(8),
        .IDLE_GAP  (6),
        .MAX_FRAME (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clkIn      (clk),
        .rstNIn     (rst_n),
        .cdcRstOut  (cdc_rst),
        .cdcDataIn  (cdc_data),
        .cdcValidIn (cdc_valid),
        .cdcErrIn   (cdc_err),
        .enIn       (en),
        .dataOut    (data),
        .validOut   (valid),
        .sofOut     (sof),
        .eofOut     (eof),
        .frameErrOut(frame_err),
        .errCntOut  (err_cnt),
        .frameCntOut(frame_cnt)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output byte with the index of the edge that produced it.
    always @(negedge clk) begin
        if (valid) evq.push_back('{d: data, s: sof, e: eof, fe: frame_err, t: cyc});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int unsigned acc);
        cdc_data  = b;
        cdc_valid = 1'b1;
        step();
        acc       = cyc;
        cdc_valid = 1'b0;
        cdc_data  = 8'h00;
    endtask

    task automatic check_events(input string name, input ev_t exp[], input int n);
        compared++;
        if (evq.size() !== n) begin
            mismatched++;
            $display("FAIL %s event count: got %0d want %0d", name, evq.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            if (i < evq.size()) begin
                compared++;
                if (evq[i] !== exp[i]) begin
                    mismatched++;
                    $display("FAIL %s event %0d: got d=%h s=%b e=%b fe=%b t=%0d want d=%h s=%b e=%b fe=%b t=%0d",
                             name, i, evq[i].d, evq[i].s, evq[i].e, evq[i].fe, evq[i].t,
                             exp[i].d, exp[i].s, exp[i].e, exp[i].fe, exp[i].t);
                end
            end
        end
    endtask

    task automatic test_reset();
        int n;
        logic other_nonzero;
        rst_n = 1'b0; cdc_data = 8'h00; cdc_valid = 1'b0; cdc_err = 1'b0; en = 1'b1;
        step(); step();
        compared++;
        if ({cdc_rst, data, valid, sof, eof, frame_err, err_cnt, frame_cnt} !== {1'b1, 8'h00, 4'b0, {(2*CNT_W){1'b0}}}) begin
            mismatched++;
            $display("FAIL reset outputs: got rst=%b d=%h v=%b ec=%0d fc=%0d want rst=1 all else 0",
                     cdc_rst, data, valid, err_cnt, frame_cnt);
        end
        rst_n = 1'b1;
        n = 0;
        other_nonzero = 1'b0;
        while (cdc_rst && n < 20) begin
            step();
            n++;
            if ({data, valid, sof, eof, frame_err, err_cnt, frame_cnt} !== '0) other_nonzero = 1'b1;
        end
        compared++;
        if (n !== 8) begin
            mismatched++;
            $display("FAIL startup cdcRst length: got %0d want 8", n);
        end
        repeat (10) begin
            step();
            if ({data, valid, sof, eof, frame_err, err_cnt, frame_cnt} !== '0) other_nonzero = 1'b1;
        end
        compared++;
        if (other_nonzero !== 1'b0) begin
            mismatched++;
            $display("FAIL startup outputs quiet: got nonzero=%b want 0", other_nonzero);
        end
    endtask

    task automatic test_normal_frame();
        int unsigned a1, a2, a3;
        ev_t exp[];
        evq.delete();
        send_byte(8'h11, a1); step();
        send_byte(8'h22, a2); step();
        send_byte(8'h33, a3);
        repeat (10) step();
        exp = new[3];
        exp[0] = '{d: 8'h11, s: 1'b1, e: 1'b0, fe: 1'b0, t: a2};
        exp[1] = '{d: 8'h22, s: 1'b0, e: 1'b0, fe: 1'b0, t: a3};
        exp[2] = '{d: 8'h33, s: 1'b0, e: 1'b1, fe: 1'b0, t: a3 + 7};
        check_events("normal", exp, 3);
        compared++;
        if (frame_cnt !== 2'd1) begin
            mismatched++;
            $display("FAIL normal frameCnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_single_byte();
        int unsigned a1;
        ev_t exp[];
        evq.delete();
        send_byte(8'hAA, a1);
        repeat (10) step();
        exp = new[1];
        exp[0] = '{d: 8'hAA, s: 1'b1, e: 1'b1, fe: 1'b0, t: a1 + 7};
        check_events("single", exp, 1);
        compared++;
        if (frame_cnt !== 2'd2) begin
            mismatched++;
            $display("FAIL single frameCnt: got %0d want 2", frame_cnt);
        end
    endtask

    // Exactly MAX_FRAME bytes on consecutive cycles; enIn dropped mid-frame.
    task automatic test_back_to_back();
        int unsigned a[4];
        ev_t exp[];
        evq.delete();
        send_byte(8'hA0, a[0]);
        en = 1'b0;
        for (int i = 1; i < 4; i++) send_byte(8'hA0 + 8'(i), a[i]);
        repeat (10) step();
        en = 1'b1;
        exp = new[4];
        exp[0] = '{d: 8'hA0, s: 1'b1, e: 1'b0, fe: 1'b0, t: a[1]};
        exp[1] = '{d: 8'hA1, s: 1'b0, e: 1'b0, fe: 1'b0, t: a[2]};
        exp[2] = '{d: 8'hA2, s: 1'b0, e: 1'b0, fe: 1'b0, t: a[3]};
        exp[3] = '{d: 8'hA3, s: 1'b0, e: 1'b1, fe: 1'b0, t: a[3] + 7};
        check_events("b2b", exp, 4);
        compared++;
        if (frame_cnt !== 2'd3) begin
            mismatched++;
            $display("FAIL b2b frameCnt: got %0d want 3", frame_cnt);
        end
    endtask

    task automatic test_error();
        int unsigned a1, a2, e;
        int unsigned junk;
        int n;
        ev_t exp[];
        evq.delete();
        send_byte(8'h01, a1); step();
        send_byte(8'h02, a2); step();
        cdc_err = 1'b1;
        step();
        e = cyc;
        cdc_err = 1'b0;
        compared++;
        if ({cdc_rst, err_cnt, frame_cnt} !== {1'b1, 2'd1, 2'd3}) begin
            mismatched++;
            $display("FAIL err status: got rst=%b ec=%0d fc=%0d want rst=1 ec=1 fc=3",
                     cdc_rst, err_cnt, frame_cnt);
        end
        n = 0;
        while (cdc_rst && n < 20) begin
            cdc_err = (n == 2);
            step();
            cdc_err = 1'b0;
            n++;
        end
        compared++;
        if (n !== 8) begin
            mismatched++;
            $display("FAIL err cdcRst length: got %0d want 8", n);
        end
        // Now in WAIT_IDLE: a byte and an error here must both be ignored.
        send_byte(8'hEE, junk);
        step();
        cdc_err = 1'b1; step(); cdc_err = 1'b0;
        repeat (12) step();
        exp = new[2];
        exp[0] = '{d: 8'h01, s: 1'b1, e: 1'b0, fe: 1'b0, t: a2};
        exp[1] = '{d: 8'h02, s: 1'b0, e: 1'b1, fe: 1'b1, t: e};
        check_events("error", exp, 2);
        compared++;
        if ({err_cnt, frame_cnt} !== {2'd1, 2'd3}) begin
            mismatched++;
            $display("FAIL err counters after recovery: got ec=%0d fc=%0d want ec=1 fc=3", err_cnt, frame_cnt);
        end
    endtask

    task automatic test_oversize();
        int unsigned a[6];
        int unsigned c1;
        ev_t exp[];
        evq.delete();
        for (int i = 0; i < 6; i++) send_byte(8'hB1 + 8'(i), a[i]);
        repeat (10) step();
        exp = new[4];
        exp[0] = '{d: 8'hB1, s: 1'b1, e: 1'b0, fe: 1'b0, t: a[1]};
        exp[1] = '{d: 8'hB2, s: 1'b0, e: 1'b0, fe: 1'b0, t: a[2]};
        exp[2] = '{d: 8'hB3, s: 1'b0, e: 1'b0, fe: 1'b0, t: a[3]};
        exp[3] = '{d: 8'hB4, s: 1'b0, e: 1'b1, fe: 1'b1, t: a[4]};
        check_events("oversize", exp, 4);
        compared++;
        if (frame_cnt !== 2'd3) begin
            mismatched++;
            $display("FAIL oversize frameCnt: got %0d want 3", frame_cnt);
        end
        evq.delete();
        send_byte(8'hC1, c1);
        repeat (10) step();
        exp = new[1];
        exp[0] = '{d: 8'hC1, s: 1'b1, e: 1'b1, fe: 1'b0, t: c1 + 7};
        check_events("after_oversize", exp, 1);
        // Fourth good frame: the 2-bit counter must stick at 3, not wrap.
        compared++;
        if (frame_cnt !== 2'd3) begin
            mismatched++;
            $display("FAIL frameCnt saturation: got %0d want 3", frame_cnt);
        end
    endtask

    task automatic test_enable();
        int unsigned junk, b;
        ev_t exp[];
        evq.delete();
        en = 1'b0;
        send_byte(8'hD1, junk);
        send_byte(8'hD2, junk);
        repeat (10) step();
        compared++;
        if (evq.size() !== 0) begin
            mismatched++;
            $display("FAIL disabled frame output: got %0d events want 0", evq.size());
        end
        en = 1'b1;
        send_byte(8'h55, b);
        repeat (10) step();
        exp = new[1];
        exp[0] = '{d: 8'h55, s: 1'b1, e: 1'b1, fe: 1'b0, t: b + 7};
        check_events("enable", exp, 1);
    endtask

    task automatic test_async_reset();
        int unsigned junk;
        evq.delete();
        send_byte(8'hE1, junk);
        send_byte(8'hE2, junk);
        rst_n = 1'b0;
        #1;
        compared++;
        if ({cdc_rst, data, valid, err_cnt, frame_cnt} !== {1'b1, 8'h00, 1'b0, {(2*CNT_W){1'b0}}}) begin
            mismatched++;
            $display("FAIL async reset: got rst=%b d=%h v=%b ec=%0d fc=%0d want rst=1 rest 0",
                     cdc_rst, data, valid, err_cnt, frame_cnt);
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        compared++;
        if (evq.size() !== 0) begin
            mismatched++;
            $display("FAIL partial frame after reset: got %0d events want 0", evq.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_single_byte();
        test_back_to_back();
        test_error();
        test_oversize();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
